// File: rtl/photon_reg_xfer.sv
// photon_reg_xfer
//   Moves a run of consecutive core registers between the core register file
//   and a local buffer (SAVE: core -> buffer, RESTORE: buffer -> core).
//   The register-file read port is borrowed only when the core leaves rs1
//   unused. The write port is borrowed only when there is no core writeback.
//
// Ports
//   clk, Rst             clock, synchronous active-high reset
//   cmd_*                command handshake (valid/ready, dir, base, count)
//   busy, done           transfer in progress / one-cycle completion pulse
//   core_rs1_free,
//   adr_rs1              core read-port usage this cycle
//   adr_photon_rs1       photon read address (0 when not borrowing)
//   IF_ID_dout_rs1       register-file read data, same cycle as the address
//   MEM_WB_*, mem_hold   core writeback activity this cycle
//   photon_regwrite,
//   addr_corereg_photon,
//   photon_data_out      photon write strobe, address and data
//   buf_rd_*             accelerator buffer read, combinational
//   buf_wr_*             accelerator buffer write, ignored while busy
module photon_reg_xfer #(
    parameter int BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [4:0]  cmd_base,
    input  logic [3:0]  cmd_count,
    output logic        busy,
    output logic        done,
    input  logic        core_rs1_free,
    input  logic [4:0]  adr_rs1,
    output logic [4:0]  adr_photon_rs1,
    input  logic [31:0] IF_ID_dout_rs1,
    input  logic        MEM_WB_regwrite,
    input  logic [4:0]  MEM_WB_rd,
    input  logic        mem_hold,
    output logic        photon_regwrite,
    output logic [4:0]  addr_corereg_photon,
    output logic [31:0] photon_data_out,
    input  logic [2:0]  buf_rd_addr,
    output logic [31:0] buf_rd_data,
    input  logic        buf_wr_en,
    input  logic [2:0]  buf_wr_addr,
    input  logic [31:0] buf_wr_data
);

    localparam int IW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  base_q;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic [31:0] buf_mem [BUF_DEPTH];

    logic [3:0]  cnt_clamp;
    logic [4:0]  cur_addr;
    logic        last;
    logic        read_ok;
    logic        core_wr;
    logic        adv;

    assign cnt_clamp = (cmd_count > 4'(BUF_DEPTH)) ? 4'(BUF_DEPTH) : cmd_count;
    // 5-bit add: the register index wraps from x31 back to x0 on purpose.
    assign cur_addr  = base_q + 5'(idx_q);
    assign last      = (idx_q + 4'd1) == cnt_q;
    assign read_ok   = core_rs1_free && (adr_rs1 == 5'd0);
    assign core_wr   = MEM_WB_regwrite && (MEM_WB_rd != 5'd0) && !mem_hold;

    assign buf_rd_data = buf_mem[buf_rd_addr];

    always_comb begin
        state_nxt           = state;
        adv                 = 1'b0;
        cmd_ready           = 1'b0;
        busy                = 1'b0;
        done                = 1'b0;
        adr_photon_rs1      = 5'd0;
        photon_regwrite     = 1'b0;
        addr_corereg_photon = 5'd0;
        photon_data_out     = 32'd0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cnt_clamp == 4'd0) state_nxt = S_DONE;
                    else if (cmd_dir)      state_nxt = S_RESTORE;
                    else                   state_nxt = S_SAVE;
                end
            end
            S_SAVE: begin
                busy = 1'b1;
                // Address stays 0 on stall cycles so the core's x0 read is untouched.
                if (read_ok) begin
                    adr_photon_rs1 = cur_addr;
                    adv            = 1'b1;
                    if (last) state_nxt = S_DONE;
                end
            end
            S_RESTORE: begin
                busy = 1'b1;
                if (!core_wr) begin
                    // x0 target: slot is consumed but no write is issued.
                    photon_regwrite     = (cur_addr != 5'd0);
                    addr_corereg_photon = cur_addr;
                    photon_data_out     = buf_mem[idx_q[IW-1:0]];
                    adv                 = 1'b1;
                    if (last) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state  <= S_IDLE;
            base_q <= 5'd0;
            cnt_q  <= 4'd0;
            idx_q  <= 4'd0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cmd_valid) begin
                base_q <= cmd_base;
                cnt_q  <= cnt_clamp;
                idx_q  <= 4'd0;
            end else if (adv) begin
                idx_q <= idx_q + 4'd1;
            end
            if (state == S_SAVE && adv)
                buf_mem[idx_q[IW-1:0]] <= (cur_addr == 5'd0) ? 32'd0 : IF_ID_dout_rs1;
            else if (!busy && buf_wr_en)
                buf_mem[buf_wr_addr] <= buf_wr_data;
        end
    end

endmodule

// File: doc/photon_reg_xfer.md
# photon_reg_xfer

Register-transfer engine for the photon coprocessor port of the core register file. It drives that port's read address and write path. On command it either saves a run of consecutive core registers into a local 8-entry buffer, or restores the buffer into core registers. It borrows the read port only on cycles the core does not use rs1, and the write port only on cycles with no core writeback.

## Interface
Parameters:
- BUF_DEPTH, 8, number of 32-bit buffer entries; maximum transfer length.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_dir  in  1  0 = SAVE (core to buffer), 1 = RESTORE (buffer to core).
- cmd_base  in  5  first core register index.
- cmd_count  in  4  number of registers. 0 = no-op. Values above BUF_DEPTH clamp to BUF_DEPTH.
- busy  out  1  high in SAVE or RESTORE.
- done  out  1  one-cycle pulse at command completion.
- core_rs1_free  in  1  core decode is not consuming rs1 this cycle.
- adr_rs1  in  5  core rs1 read address.
- adr_photon_rs1  out  5  photon read address to the register file.
- IF_ID_dout_rs1  in  32  register-file rs1 read data; combinational with the addresses.
- MEM_WB_regwrite  in  1  core writeback enable.
- MEM_WB_rd  in  5  core writeback destination.
- mem_hold  in  1  core writeback hold.
- photon_regwrite  out  1  photon write strobe.
- addr_corereg_photon  out  5  photon write address.
- photon_data_out  out  32  photon write data.
- buf_rd_addr  in  3  accelerator buffer read index.
- buf_rd_data  out  32  combinational buffer read.
- buf_wr_en  in  1  accelerator buffer write; ignored while busy.
- buf_wr_addr  in  3  accelerator buffer write index.
- buf_wr_data  in  32  accelerator buffer write data.

## Operation
- States: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - On cmd_valid, latch base, dir and the clamped count, and clear idx to 0.
  - Next state is SAVE or RESTORE by dir, or DONE if the count is 0.
- Register address is (base + idx) mod 32. Wrap-around is intended: base 30, count 4 gives 30, 31, 0, 1.
- read_ok = core_rs1_free && adr_rs1 == 0.
- adr_photon_rs1:
  - Equals (base + idx) mod 32 only in SAVE with read_ok.
  - Otherwise 0, so core reads of x0 are never corrupted.
- SAVE:
  - On read_ok cycles, buf[idx] <= IF_ID_dout_rs1 and idx increments.
  - If the address is 0, the captured value is 0.
  - Otherwise the state holds without capture.
  - Leaves to DONE after capturing the last index.
- core_wr = MEM_WB_regwrite && MEM_WB_rd != 0 && !mem_hold.
- RESTORE:
  - On cycles with !core_wr, photon_regwrite = 1, addr_corereg_photon = base + idx, photon_data_out = buf[idx], and idx increments.
  - If the target address is 0, the strobe is suppressed but idx still advances; the x0 write guard lives here.
  - While core_wr is high, the strobe is 0 and the state holds.
  - Leaves to DONE after the last index.
- DONE: done = 1 for one cycle, then IDLE.
- Write outputs are combinational from state, idx and core_wr. They are 0 outside RESTORE.
- Buffer accelerator writes take effect only when !busy. buf_rd_data is valid in all states.
- Reset: state IDLE, idx 0, all buffer entries 0. Outputs become cmd_ready 1, busy 0, done 0, adr_photon_rs1 0, photon_regwrite 0, addr_corereg_photon 0, photon_data_out 0. Reset mid-transfer aborts immediately: no further strobes and no done.

## Timing
- cmd_valid sampled at edge T with cmd_ready high:
  - busy from T+1.
  - With no stalls, SAVE or RESTORE occupies cycles T+1 through T+N.
  - done during T+N+1.
  - cmd_ready during T+N+2.
- Each stall cycle (!read_ok in SAVE, core_wr in RESTORE) adds exactly one cycle.
- Count 0: done during T+1.
- SAVE capture and the register read occur in the same cycle; there is no read latency.
- A RESTORE strobe is written by the register file at the edge ending the strobe cycle.
- cmd_valid while !cmd_ready is ignored; no queueing.

## Test plan
- SAVE with regs x5..x8 = 0x11, 0x22, 0x33, 0x44, base 5, count 4, core_rs1_free = 1 → buffer[0..3] holds those values; done 5 cycles after accept.
- SAVE base 30, count 4, core_rs1_free toggling 1,0,1,0,... → addresses 30, 31, 0, 1; buffer[2] = 0; done after 8 stall-inclusive cycles; adr_photon_rs1 = 0 on every free=0 cycle.
- RESTORE with buffer = 0xA0..0xA7, base 28, count 8 → strobes on x28–x31 and x1–x3; no strobe at address 0; x28 = 0xA0, x3 = 0xA7.
- RESTORE while core_wr is held high for 3 cycles mid-burst → exactly 3 stall cycles with photon_regwrite = 0; final register contents are unchanged from the unstalled case.
- Count 0 and count 15 → immediate done in the first case; 8 transfers in the second.
- Rst asserted at the 2nd RESTORE strobe → no later strobes, no done, buffer all 0, cmd_ready = 1 the next cycle.
